// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a byte FIFO that is
// serialised on o_tx with a programmable bit period (BAUDDIV clocks per bit).
module mmio_uart_tx #(
    parameter logic [29:0] BASE_ADDR   = 30'h0400_0000,
    parameter int unsigned FIFO_AW     = 3,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_mmio_addr,
    input  logic [31:0] i_mmio_data,
    input  logic [3:0]  i_mmio_mask,
    input  logic        i_mmio_wren,
    output logic [31:0] o_mmio_data,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [15:0]        div, cnt, cnt_n, div_eff, reload;
    logic [2:0]         bit_idx, bit_idx_n;
    logic [7:0]         shifter, shifter_n;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow;
    logic               hit, full, empty, line_active;
    logic               push_req, push_ok, pop, ovf_clr;
    logic [1:0]         off;
    logic [31:0]        status, rd_mux;
    logic               unused_bits;

    assign unused_bits = ^{i_mmio_data[31:16], i_mmio_mask[3:2]};

    assign hit      = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
    assign off      = i_mmio_addr[1:0];
    assign push_req = i_mmio_wren & hit & (off == 2'd0) & i_mmio_mask[0];
    assign ovf_clr  = i_mmio_wren & hit & (off == 2'd1) & i_mmio_mask[0] & i_mmio_data[3];

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign push_ok = push_req & ~full;

    assign line_active = (state != IDLE);
    assign o_busy      = line_active | ~empty;

    assign div_eff = (div == '0) ? 16'd1 : div;
    assign reload  = div_eff - 16'd1;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_mmio_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DEFAULT_DIV;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (i_mmio_wren && hit && off == 2'd2) begin
                if (i_mmio_mask[0]) div[7:0]  <= i_mmio_data[7:0];
                if (i_mmio_mask[1]) div[15:8] <= i_mmio_data[15:8];
            end
        end
    end

    always_comb begin
        status                 = '0;
        status[0]              = line_active;
        status[1]              = full;
        status[2]              = empty;
        status[3]              = overflow;
        status[FIFO_AW+8:8]    = count;
        rd_mux                 = '0;
        if (hit) begin
            case (off)
                2'd1:    rd_mux = status;
                2'd2:    rd_mux = {16'h0000, div};
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mmio_data <= '0;
        end else begin
            o_mmio_data <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shifter <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shifter <= shifter_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        pop       = 1'b0;
        o_tx      = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shifter_n = mem[rd_ptr];
                    cnt_n     = reload;
                    state_n   = START;
                end
            end
            START: begin
                o_tx = 1'b0;
                if (cnt == '0) begin
                    cnt_n     = reload;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                o_tx = shifter[0];
                if (cnt == '0) begin
                    cnt_n     = reload;
                    shifter_n = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow, address decode and asynchronous reset during a frame.
module tb_mmio_uart_tx;
    localparam logic [29:0] BASE = 30'h0400_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_mask;
    logic        mmio_wren;
    logic [31:0] mmio_rdata;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_q [$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_AW     (3),
        .DEFAULT_DIV (16'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mmio_addr (mmio_addr),
        .i_mmio_data (mmio_wdata),
        .i_mmio_mask (mmio_mask),
        .i_mmio_wren (mmio_wren),
        .o_mmio_data (mmio_rdata),
        .o_tx        (tx),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mmio_write(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_mask  = mask;
        mmio_wren  = 1'b1;
        @(negedge clk);
        mmio_wren  = 1'b0;
    endtask

    task automatic mmio_read(input logic [29:0] addr, output logic [31:0] data);
        @(negedge clk);
        mmio_addr = addr;
        mmio_wren = 1'b0;
        @(negedge clk);
        data = mmio_rdata;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // 8N1 receiver for P=4: sample each bit in its middle
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && tx == 1'b0) begin
                repeat (2) @(negedge clk);
                for (int unsigned i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                check("rx_stop", {31'd0, tx}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  pat;
        int unsigned lows;

        rst_n      = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
        mmio_mask  = '0;
        mmio_wren  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", mmio_rdata,   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mmio_read(BASE + 30'd1, rd);
        check("rst_status", rd, 32'h0000_0004);
        mmio_read(BASE + 30'd2, rd);
        check("rst_div", rd, 32'h0000_0004);

        // 0x55: start, bits LSB first, stop; each level for 4 clocks
        pat = 10'b1010101010;
        mmio_write(BASE, 32'h0000_0055, 4'b0001);
        check("pre_start_tx", {31'd0, tx}, 32'd1);
        for (int unsigned k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("frame55_c%0d", k), {31'd0, tx}, {31'd0, pat[k/4]});
            if (k == 20) check("busy_mid", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("after_stop_tx",   {31'd0, tx},   32'd1);
        check("after_stop_busy", {31'd0, busy}, 32'd0);

        // writes without mask bit 0 must not push
        mmio_write(BASE, 32'hFFFF_FF41, 4'b1110);
        repeat (3) @(negedge clk);
        check("mask_busy", {31'd0, busy}, 32'd0);
        mmio_read(BASE + 30'd1, rd);
        check("mask_status", rd, 32'h0000_0004);
        mmio_write(BASE + 30'd2, 32'h0000_0102, 4'b0001);
        mmio_read(BASE + 30'd2, rd);
        check("div_lowbyte", rd, 32'h0000_0002);
        mmio_write(BASE + 30'd2, 32'hABCD_0004, 4'b0011);
        mmio_read(BASE + 30'd2, rd);
        check("div_restore", rd, 32'h0000_0004);

        // overflow: 0x00 popped at once, 0x01..0x08 fill FIFO, 0x09 dropped
        rx_q.delete();
        rx_en = 1'b1;
        @(negedge clk);
        mmio_addr = BASE;
        mmio_mask = 4'b0001;
        mmio_wren = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            mmio_wdata = i;
            @(negedge clk);
        end
        mmio_wren = 1'b0;
        mmio_read(BASE + 30'd1, rd);
        check("ovf_status", rd, 32'h0000_080B);
        mmio_write(BASE + 30'd1, 32'h0000_0008, 4'b0001);
        mmio_read(BASE + 30'd1, rd);
        check("ovf_cleared", rd, 32'h0000_0803);
        wait_idle("ovf_drain");
        repeat (4) @(negedge clk);
        rx_en = 1'b0;
        check("rx_count", rx_q.size(), 32'd9);
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, i);
        end
        mmio_read(BASE + 30'd1, rd);
        check("drained_status", rd, 32'h0000_0004);

        // decode window
        mmio_write(BASE + 30'd4, 32'h0000_0077, 4'b0001);
        repeat (3) @(negedge clk);
        check("oow_busy", {31'd0, busy}, 32'd0);
        mmio_read(BASE + 30'd4, rd);
        check("oow_read", rd, 32'd0);
        mmio_read(BASE + 30'd5, rd);
        check("oow_read_status", rd, 32'd0);
        mmio_read(BASE + 30'd3, rd);
        check("reserved_read", rd, 32'd0);
        mmio_read(BASE, rd);
        check("txdata_read", rd, 32'd0);

        // asynchronous reset during bit 3 of 0xA5 (bit 3 = 0), second byte queued
        mmio_write(BASE, 32'h0000_00A5, 4'b0001);
        mmio_write(BASE, 32'h0000_003C, 4'b0001);
        repeat (16) @(negedge clk);
        check("bit3_low", {31'd0, tx}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx",   {31'd0, tx},   32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mmio_read(BASE + 30'd1, rd);
        check("post_rst_status", rd, 32'h0000_0004);
        lows = 0;
        for (int unsigned k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx == 1'b0 || busy == 1'b1) lows++;
        end
        check("post_rst_quiet", lows, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
